// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B, one bit per clock,
// LSB first, through one full-subtractor cell and a borrow flop, behind a
// start/busy/done handshake.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          synchronous reset, active-high
//   i_start        operation request, sampled only in IDLE
//   i_a, i_b       minuend / subtrahend, captured on an accepted start
//   o_busy         high while an operation is in flight (SHIFT or DONE)
//   o_done         one-cycle pulse, results valid this cycle
//   o_diff         A - B mod 2^WIDTH, held until the next operation completes
//   o_borrow_out   unsigned A < B, held with o_diff
//   o_overflow     signed overflow of A - B, held with o_diff
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow_out,
  output logic             o_overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_d_sr;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_a_msb;
  logic               r_b_msb;

  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow_out;
  logic               r_overflow;

  logic               w_ai;
  logic               w_bi;
  logic               w_d;
  logic               w_bout;
  logic               w_last;
  logic [WIDTH-1:0]   w_d_next;

  // Full-subtractor cell on the current LSBs plus the running borrow
  assign w_ai     = r_a_sr[0];
  assign w_bi     = r_b_sr[0];
  assign w_d      = w_ai ^ w_bi ^ r_borrow;
  assign w_bout   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_d_next = {w_d, r_d_sr[WIDTH-1:1]};

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next_state = S_SHIFT;
      S_SHIFT: if (w_last)  w_next_state = S_DONE;
      S_DONE:               w_next_state = S_IDLE;
      default:              w_next_state = S_IDLE;
    endcase
  end

  // State register; busy/done are registered decodes of the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= (w_next_state == S_DONE);
    end
  end

  // Operand capture, bit-serial datapath and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_sr       <= '0;
      r_b_sr       <= '0;
      r_d_sr       <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a_sr   <= i_a;
            r_b_sr   <= i_b;
            r_a_msb  <= i_a[WIDTH-1];
            r_b_msb  <= i_b[WIDTH-1];
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_SHIFT: begin
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_d_sr   <= w_d_next;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // The final d is the result sign bit
            r_diff       <= w_d_next;
            r_borrow_out <= w_bout;
            r_overflow   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_diff       = r_diff;
  assign o_borrow_out = r_borrow_out;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 directed ops,
// WIDTH=4 exhaustive back-to-back sweep).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bo8, ov8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bo4, ov4;
  logic [3:0] diff4;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_a(a8), .i_b(b8),
    .o_busy(busy8), .o_done(done8), .o_diff(diff8),
    .o_borrow_out(bo8), .o_overflow(ov8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_a(a4), .i_b(b4),
    .o_busy(busy4), .o_done(done4), .o_diff(diff4),
    .o_borrow_out(bo4), .o_overflow(ov4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one 8-bit op and wait (bounded) for done; returns the cycle count
  // from the start edge to the done cycle and whether done was seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output int lat, output logic seen);
    start8 = 1'b1; a8 = a; b8 = b;
    tick();
    start8 = 1'b0; a8 = 'x; b8 = 'x;
    lat = 1;
    while (!done8 && lat < 20) begin
      tick();
      lat++;
    end
    seen = done8;
  endtask

  initial begin
    int   lat;
    logic seen;
    int   ndone;
    logic [7:0] cap;
    int   sa, sb, sd;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_bo",   32'(bo8),   32'd0);
    chk("rst_ov",   32'(ov8),   32'd0);
    rst = 1'b0;
    tick();

    // 1: 0x35 - 0x12
    run8(8'h35, 8'h12, lat, seen);
    chk("t1_seen", 32'(seen), 32'd1);
    chk("t1_lat",  32'(lat),  32'd9);
    chk("t1_busy", 32'(busy8), 32'd1);
    chk("t1_diff", 32'(diff8), 32'h23);
    chk("t1_bo",   32'(bo8),   32'd0);
    chk("t1_ov",   32'(ov8),   32'd0);
    tick();
    chk("t1_idle_busy", 32'(busy8), 32'd0);
    chk("t1_idle_done", 32'(done8), 32'd0);
    chk("t1_hold_diff", 32'(diff8), 32'h23);

    // 2: borrow case and zero
    run8(8'h12, 8'h35, lat, seen);
    chk("t2a_seen", 32'(seen), 32'd1);
    chk("t2a_diff", 32'(diff8), 32'hDD);
    chk("t2a_bo",   32'(bo8),   32'd1);
    chk("t2a_ov",   32'(ov8),   32'd0);
    tick();
    run8(8'h00, 8'h00, lat, seen);
    chk("t2b_seen", 32'(seen), 32'd1);
    chk("t2b_diff", 32'(diff8), 32'h00);
    chk("t2b_bo",   32'(bo8),   32'd0);
    tick();

    // 3: signed overflow both directions
    run8(8'h80, 8'h01, lat, seen);
    chk("t3a_seen", 32'(seen), 32'd1);
    chk("t3a_diff", 32'(diff8), 32'h7F);
    chk("t3a_bo",   32'(bo8),   32'd0);
    chk("t3a_ov",   32'(ov8),   32'd1);
    tick();
    run8(8'h7F, 8'hFF, lat, seen);
    chk("t3b_seen", 32'(seen), 32'd1);
    chk("t3b_diff", 32'(diff8), 32'h80);
    chk("t3b_bo",   32'(bo8),   32'd1);
    chk("t3b_ov",   32'(ov8),   32'd1);
    tick();

    // 4: start held high, operands changed mid-op
    start8 = 1'b1; a8 = 8'h35; b8 = 8'h12;
    tick();
    a8 = 8'hFF; b8 = 8'hFF;
    ndone = 0; cap = '0;
    repeat (8) begin
      tick();
      if (done8) begin
        ndone++;
        cap = diff8;
      end
    end
    chk("t4_ndone", 32'(ndone), 32'd1);
    chk("t4_diff",  32'(cap),   32'h23);
    tick();
    chk("t4_idle_busy", 32'(busy8), 32'd0);
    chk("t4_idle_done", 32'(done8), 32'd0);
    tick();
    chk("t4_reaccept_busy", 32'(busy8), 32'd1);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 20) begin
      tick();
      lat++;
    end
    chk("t4b_lat",  32'(lat),   32'd9);
    chk("t4b_diff", 32'(diff8), 32'h00);
    chk("t4b_bo",   32'(bo8),   32'd0);
    tick();

    // 5: reset four cycles into an op (prior result is non-zero)
    run8(8'h80, 8'h01, lat, seen);
    chk("t5_pre_diff", 32'(diff8), 32'h7F);
    tick();
    start8 = 1'b1; a8 = 8'h35; b8 = 8'h12;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 32'(busy8), 32'd0);
    chk("t5_done", 32'(done8), 32'd0);
    chk("t5_diff", 32'(diff8), 32'd0);
    chk("t5_bo",   32'(bo8),   32'd0);
    chk("t5_ov",   32'(ov8),   32'd0);
    ndone = 0;
    repeat (12) begin
      tick();
      if (done8) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 32'd0);
    run8(8'h12, 8'h35, lat, seen);
    chk("t5_post_seen", 32'(seen), 32'd1);
    chk("t5_post_diff", 32'(diff8), 32'hDD);
    chk("t5_post_bo",   32'(bo8),   32'd1);
    tick();

    // 6: WIDTH=4 exhaustive, back-to-back
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        start4 = 1'b1; a4 = 4'(ia); b4 = 4'(ib);
        tick();
        start4 = 1'b0; a4 = 'x; b4 = 'x;
        lat = 1;
        while (!done4 && lat < 12) begin
          chk("w4_busy", 32'(busy4), 32'd1);
          tick();
          lat++;
        end
        sa = (ia > 7) ? ia - 16 : ia;
        sb = (ib > 7) ? ib - 16 : ib;
        sd = sa - sb;
        chk("w4_lat",  32'(lat),   32'd5);
        chk("w4_busy_done", 32'(busy4), 32'd1);
        chk("w4_diff", 32'(diff4), 32'((ia - ib) & 15));
        chk("w4_bo",   32'(bo4),   32'(ia < ib));
        chk("w4_ov",   32'(ov4),   32'((sd > 7) || (sd < -8)));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
